// File: rtl/nibble_frame_master.sv
// Arbitrating scl/sda frame master: start, 4 data bits MSB first, stop; each phase lasts DIV clk cycles.
// Define NIBBLE_FRAME_MASTER_FIXED_PRI_EN for fixed (lowest index) priority instead of round-robin.
module nibble_frame_master #(
  parameter int NREQ = 4,
  parameter int DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic              scl,
  output logic              sda
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE, START_A, START_B, BIT_LO, BIT_HI, STOP_LO, STOP_HI, STOP_END
  } state_t;

  state_t          state;
  logic [PW-1:0]   phase;
  logic [1:0]      bit_cnt;
  logic [3:0]      shreg;
  logic            phase_last;
  logic            done_next;
  logic            win_found;
  logic [IW-1:0]   win_idx;

  assign phase_last = (phase == PW'(DIV - 1));

`ifdef NIBBLE_FRAME_MASTER_FIXED_PRI_EN
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[(int'(ptr) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
`endif

  // done is registered, so it is raised one edge ahead of the final STOP_END cycle.
  always_comb begin
    done_next = 1'b0;
    if (DIV == 1) done_next = (state == STOP_HI);
    else          done_next = (state == STOP_END) && (phase == PW'(DIV - 2));
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= 2'd3;
      shreg   <= '0;
      scl     <= 1'b1;
      sda     <= 1'b1;
      busy    <= 1'b0;
      gnt     <= '0;
      done    <= 1'b0;
`ifndef NIBBLE_FRAME_MASTER_FIXED_PRI_EN
      ptr     <= IW'(NREQ - 1);
`endif
    end else begin
      gnt  <= '0;
      done <= done_next;
      if (state == IDLE) begin
        phase <= '0;
        if (win_found) begin
          gnt     <= NREQ'(1) << win_idx;
          shreg   <= req_data[4*int'(win_idx) +: 4];
          bit_cnt <= 2'd3;
          busy    <= 1'b1;
          state   <= START_A;
`ifndef NIBBLE_FRAME_MASTER_FIXED_PRI_EN
          ptr     <= win_idx;
`endif
        end
      end else if (!phase_last) begin
        phase <= phase + PW'(1);
      end else begin
        phase <= '0;
        case (state)
          START_A: begin
            state <= START_B;
            sda   <= 1'b0;
          end
          START_B: begin
            state <= BIT_LO;
            scl   <= 1'b0;
            sda   <= shreg[3];
          end
          BIT_LO: begin
            state <= BIT_HI;
            scl   <= 1'b1;
          end
          BIT_HI: begin
            scl <= 1'b0;
            if (bit_cnt != 2'd0) begin
              bit_cnt <= bit_cnt - 2'd1;
              shreg   <= {shreg[2:0], 1'b0};
              sda     <= shreg[2];
              state   <= BIT_LO;
            end else begin
              sda   <= 1'b0;
              state <= STOP_LO;
            end
          end
          STOP_LO: begin
            state <= STOP_HI;
            scl   <= 1'b1;
          end
          STOP_HI: begin
            state <= STOP_END;
            sda   <= 1'b1;
          end
          STOP_END: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nibble_frame_master.sv
// Scoreboard bench: three masters (DIV 4, 2, 1); a negedge monitor reconstructs each frame and
// compares it with the expected entry queued by the stimulus.
module tb_nibble_frame_master;

  localparam int NU = 3;
  localparam int DIVS [NU] = '{4, 2, 1};

  typedef struct {
    int         unit;
    logic [3:0] gnt;
    logic [3:0] code;
    int         gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_v      [NU];
  logic [3:0]  req_v      [NU];
  logic [15:0] req_data_v [NU];
  logic [3:0]  gnt_v      [NU];
  logic        busy_v     [NU];
  logic        done_v     [NU];
  logic        scl_v      [NU];
  logic        sda_v      [NU];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  nibble_frame_master #(.NREQ(4), .DIV(4)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .req_data(req_data_v[0]),
    .gnt(gnt_v[0]), .busy(busy_v[0]), .done(done_v[0]), .scl(scl_v[0]), .sda(sda_v[0]));
  nibble_frame_master #(.NREQ(4), .DIV(2)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .req_data(req_data_v[1]),
    .gnt(gnt_v[1]), .busy(busy_v[1]), .done(done_v[1]), .scl(scl_v[1]), .sda(sda_v[1]));
  nibble_frame_master #(.NREQ(4), .DIV(1)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .req_data(req_data_v[2]),
    .gnt(gnt_v[2]), .busy(busy_v[2]), .done(done_v[2]), .scl(scl_v[2]), .sda(sda_v[2]));

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-unit frame reconstruction state.
  logic       prev_scl [NU];
  logic       prev_sda [NU];
  logic [3:0] frame_gnt [NU];
  logic [3:0] bits_r [NU];
  int nbits [NU], busy_cnt [NU], scl_low [NU], start_f [NU], stop_r [NU];
  int overlap [NU], frame_gap [NU], last_gnt [NU], done_cnt [NU];

  initial begin
    for (int u = 0; u < NU; u++) begin
      prev_scl[u] = 1'b1; prev_sda[u] = 1'b1; frame_gnt[u] = '0; bits_r[u] = '0;
      nbits[u] = 0; busy_cnt[u] = 0; scl_low[u] = 0; start_f[u] = 0; stop_r[u] = 0;
      overlap[u] = 0; frame_gap[u] = 0; last_gnt[u] = 0; done_cnt[u] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < NU; u++) begin
      if (!rst_v[u]) begin
        if (gnt_v[u] != 4'b0) begin
          frame_gnt[u] = gnt_v[u]; bits_r[u] = '0; nbits[u] = 0; busy_cnt[u] = 0;
          scl_low[u] = 0; start_f[u] = 0; stop_r[u] = 0; overlap[u] = 0;
          frame_gap[u] = cyc - last_gnt[u];
          last_gnt[u] = cyc;
        end
        if (gnt_v[u] != 4'b0 && done_v[u]) overlap[u]++;
        if (busy_v[u]) begin
          busy_cnt[u]++;
          if (prev_scl[u] && !scl_v[u]) scl_low[u]++;
          if (prev_scl[u] && scl_v[u] && prev_sda[u] && !sda_v[u]) start_f[u]++;
          if (prev_scl[u] && scl_v[u] && !prev_sda[u] && sda_v[u]) stop_r[u]++;
          if (!prev_scl[u] && scl_v[u] && nbits[u] < 4) begin
            bits_r[u] = {bits_r[u][2:0], sda_v[u]};
            nbits[u]++;
          end
        end
        if (done_v[u]) begin
          done_cnt[u]++;
          if (exp_q.size() == 0) begin
            check($sformatf("u%0d_unexpected_done", u), 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("u%0d_unit", u), u, e.unit);
            check($sformatf("u%0d_gnt", u), int'(frame_gnt[u]), int'(e.gnt));
            check($sformatf("u%0d_bits", u), int'(bits_r[u]), int'(e.code));
            check($sformatf("u%0d_nbits", u), nbits[u], 4);
            check($sformatf("u%0d_busy_cycles", u), busy_cnt[u], 13 * DIVS[u]);
            check($sformatf("u%0d_scl_lows", u), scl_low[u], 5);
            check($sformatf("u%0d_start_falls", u), start_f[u], 1);
            check($sformatf("u%0d_stop_rises", u), stop_r[u], 1);
            check($sformatf("u%0d_gnt_done_overlap", u), overlap[u], 0);
            if (e.gap != 0) check($sformatf("u%0d_grant_gap", u), frame_gap[u], e.gap);
          end
        end
      end
      prev_scl[u] = scl_v[u];
      prev_sda[u] = sda_v[u];
    end
  end

  task automatic push(input int u, input logic [3:0] g, input logic [3:0] code, input int gap);
    exp_t e;
    e.unit = u; e.gnt = g; e.code = code; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input int u, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_v[u] == 4'b0 && n < max);
    check($sformatf("u%0d_gnt_seen", u), int'(gnt_v[u] != 4'b0), 1);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_reset(input int u);
    rst_v[u] = 1'b1;
    @(negedge clk);
    rst_v[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int u = 0; u < NU; u++) begin
      rst_v[u] = 1'b1; req_v[u] = '0; req_data_v[u] = '0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("u%0d_rst_scl", u), int'(scl_v[u]), 1);
      check($sformatf("u%0d_rst_sda", u), int'(sda_v[u]), 1);
      check($sformatf("u%0d_rst_busy", u), int'(busy_v[u]), 0);
      check($sformatf("u%0d_rst_gnt", u), int'(gnt_v[u]), 0);
      check($sformatf("u%0d_rst_done", u), int'(done_v[u]), 0);
      rst_v[u] = 1'b0;
    end

    // Single frame, DIV=4, code A -> bits 1010.
    req_data_v[0] = 16'h000A;
    req_v[0] = 4'b0001;
    push(0, 4'b0001, 4'hA, 0);
    wait_gnt(0, 20);
    req_v[0] = 4'b0000;
    wait_drain(200);

    // Round-robin from a fresh pointer: 0,2,0,2 with 53-cycle spacing.
    pulse_reset(0);
    req_data_v[0] = 16'h0C03;
    req_v[0] = 4'b0101;
    push(0, 4'b0001, 4'h3, 0);
    push(0, 4'b0100, 4'hC, 53);
    push(0, 4'b0001, 4'h3, 53);
    push(0, 4'b0100, 4'hC, 53);
    for (int i = 0; i < 4; i++) wait_gnt(0, 100);
    req_v[0] = 4'b0000;
    wait_drain(200);

    // Reset during BIT_HI of bit 2 (cycles 20..23 after the grant cycle), frame abandoned.
    req_data_v[0] = 16'h0000;
    req_v[0] = 4'b0010;
    wait_gnt(0, 20);
    req_v[0] = 4'b0000;
    repeat (21) @(negedge clk);
    check("abort_pre_scl", int'(scl_v[0]), 1);
    check("abort_pre_sda", int'(sda_v[0]), 0);
    d0 = done_cnt[0];
    pulse_reset(0);
    check("abort_scl", int'(scl_v[0]), 1);
    check("abort_sda", int'(sda_v[0]), 1);
    check("abort_busy", int'(busy_v[0]), 0);
    repeat (60) @(negedge clk);
    check("abort_no_done", done_cnt[0], d0);
    req_data_v[0] = 16'h0050;
    req_v[0] = 4'b0010;
    push(0, 4'b0010, 4'h5, 0);
    wait_gnt(0, 20);
    req_v[0] = 4'b0000;
    wait_drain(200);

    // Line protocol, DIV=2, code F.
    req_data_v[1] = 16'h000F;
    req_v[1] = 4'b0001;
    push(1, 4'b0001, 4'hF, 0);
    wait_gnt(1, 20);
    req_v[1] = 4'b0000;
    wait_drain(100);

    // Edge timing, DIV=1, code 6 held: 13 busy cycles + 1 IDLE between grants.
    req_data_v[2] = 16'h0006;
    req_v[2] = 4'b0001;
    push(2, 4'b0001, 4'h6, 0);
    push(2, 4'b0001, 4'h6, 14);
    wait_gnt(2, 20);
    wait_gnt(2, 30);
    req_v[2] = 4'b0000;
    wait_drain(60);

    // Requesters 1 (code 9) and 3 (code 4) held together.
    req_data_v[2] = 16'h4090;
    req_v[2] = 4'b1010;
`ifdef NIBBLE_FRAME_MASTER_FIXED_PRI_EN
    push(2, 4'b0010, 4'h9, 0);
    push(2, 4'b0010, 4'h9, 14);
    push(2, 4'b0010, 4'h9, 14);
    push(2, 4'b0010, 4'h9, 14);
`else
    push(2, 4'b0010, 4'h9, 0);
    push(2, 4'b1000, 4'h4, 14);
    push(2, 4'b0010, 4'h9, 14);
    push(2, 4'b1000, 4'h4, 14);
`endif
    for (int i = 0; i < 4; i++) wait_gnt(2, 30);
    req_v[2] = 4'b0000;
    wait_drain(60);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nibble_frame_master.md
Name: nibble_frame_master

Overview:
- Bus master that drives the two-wire scl/sda serial link into the 16-line one-hot decoder.
- Arbitrates between NREQ local requesters, each offering a 4-bit code.
- Sends the winner's code as one frame: start condition, 4 data bits MSB first, stop condition.
- Sole driver of scl/sda in the design; generates all link timing from the system clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DIV, 4, clk cycles per link phase (>=1); one frame = 13*DIV cycles.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- req  input  NREQ  per-requester request level; held until granted.
- req_data  input  4*NREQ  requester i code at bits [4i+3:4i]; sampled only at grant.
- gnt  output  NREQ  one-hot, 1-cycle pulse; marks the requester whose code was latched.
- busy  output  1  high from grant cycle through last frame cycle.
- done  output  1  1-cycle pulse on the final cycle of the frame.
- scl  output  1  serial clock line, idle high.
- sda  output  1  serial data line, idle high.

Behaviour:
- Reset: on any posedge with rst=1, all of the following take effect at that edge:
  - scl=1, sda=1, busy=0, gnt=0, done=0.
  - State=IDLE, phase counter=0, bit counter=3.
  - Round-robin pointer=NREQ-1, so requester 0 wins first.
- Reset mid-frame:
  - The frame is abandoned immediately. No done pulse.
  - The lines return to 1/1 at that edge. The receiver may see a stop-like edge; this is accepted.
- All outputs are registered. Each non-IDLE state lasts exactly DIV cycles, counted by the phase counter 0..DIV-1. The state advances when the counter reaches DIV-1.
- States, with the (scl, sda) values driven during each:
  - IDLE (1,1): if req!=0 at an edge, choose a winner, latch its code into a 4-bit shift register, and set its gnt bit for that one cycle. Also set busy=1 and go to START_A.
  - START_A (1,1).
  - START_B (1,0): start condition.
  - BIT_LO (0, current MSB of shift register). sda changes only on entry to this state.
  - BIT_HI (scl=1, sda held). At exit:
    - if bit counter>0: decrement the counter, shift left, go to BIT_LO;
    - otherwise go to STOP_LO.
  - STOP_LO (0,0).
  - STOP_HI (1,0).
  - STOP_END (1,1): stop condition. done=1 on its last cycle. busy falls and the state returns to IDLE at the following edge.
- Invariant: sda never changes while scl=1, except the START_B fall and the STOP_END rise.
- Arbitration (default): round-robin.
  - Search starts at pointer+1 and wraps modulo NREQ; the first set req bit wins.
  - The pointer is updated to the winner on grant.
- Requests:
  - A req dropped before its grant is simply not served.
  - req and data changes during a frame are ignored until the next IDLE.
- Back-to-back frames:
  - At least one IDLE cycle separates frames, with lines at 1/1.
  - A new grant can occur on that IDLE cycle.
  - Frame period under continuous requests = 13*DIV+1 cycles.
- gnt and done are never high in the same cycle. busy=0 only in IDLE.

Optional Feature:
- Macro: NIBBLE_FRAME_MASTER_FIXED_PRI_EN.
- Defined: fixed priority; the lowest-index set req bit always wins. The pointer logic is removed.
- Undefined: round-robin as above.
- Frame timing is identical in both builds.

Test Plan:
- Single frame, DIV=4:
  - Stimulus: req=4'b0001, req_data[3:0]=4'hA.
  - Required: gnt=4'b0001 for 1 cycle; busy high 52 cycles; done pulse on the 52nd busy cycle.
  - Required: sda sampled during the 4 BIT_HI phases reads 1,0,1,0.
- Round-robin:
  - Stimulus: req=4'b0101 held, codes 3 and C.
  - Required: grants alternate 0,2,0,2; bits observed 0011,1100,0011,1100; 53 cycles between grant pulses.
- Line protocol, DIV=2, code 4'hF:
  - Required: exactly one sda fall with scl=1 (START_B) and one sda rise with scl=1 (STOP_END) per frame.
  - Required: no other sda change while scl=1; scl low exactly 5 times per frame.
- Reset mid-frame, DIV=4:
  - Stimulus: assert rst for 1 cycle during BIT_HI of bit 2.
  - Required: next cycle scl=1, sda=1, busy=0; no done pulse.
  - Required: following req=4'b0010 is granted (gnt[1]) and completes normally.
- Edge timing, DIV=1:
  - Stimulus: code 4'h6, req held continuously.
  - Required: busy 13 cycles, 1 IDLE cycle, next grant; bits 0,1,1,0.
- With NIBBLE_FRAME_MASTER_FIXED_PRI_EN:
  - Stimulus: req=4'b1010 held.
  - Required: every grant is gnt=4'b0010. Without the macro, grants alternate 4'b0010, 4'b1000.
